uart_tx_arbiter: RTL and testbench

- Shares the byte-wide transmit interface of one uart_top between NUM_REQ requesters, e.g. the core's debug printer, the bootloader echo path and an error reporter.
- Uses round-robin arbitration with message-level locking. Once a requester is granted, it keeps the UART until it sends a byte flagged last, so messages never interleave on the serial line.
- An idle timeout reclaims the UART from a requester that stalls in mid-message.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants and state encoding for the UART TX arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int c_byte_w           = 8;
  localparam int c_idle_timeout_def = 125_000;

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  typedef enum logic [0:0] {
    IDLE   = c_st_idle,
    LOCKED = c_st_locked
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; searches upward from i_last+1.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0] w_cand;

  // Walk the ring from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = ID_W'((int'(i_last) + k) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Message-locked round-robin arbiter sharing one UART TX byte port.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int IDLE_TIMEOUT = c_idle_timeout_def
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ*c_byte_w-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [c_byte_w-1:0]         tx_data_o,
  output logic                        tx_valid_o,
  input  logic                        tx_ready_i,
  output logic [ID_W-1:0]             grant_id_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int c_cnt_w = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max =
      c_cnt_w'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_grant_id;
  logic [c_byte_w-1:0] r_tx_data;
  logic                r_tx_valid;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_timeout;

  logic [c_byte_w-1:0] w_bytes [NUM_REQ];
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_any;
  logic                w_locked;
  logic                w_ready_g;
  logic                w_valid_g;
  logic                w_accept;
  logic                w_acc_last;
  logic                w_expire;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_bytes[i] = req_data_i[c_byte_w*i +: c_byte_w];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req  (req_valid_i),
    .i_last (r_grant_id),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  assign w_locked   = (r_state == LOCKED);
  assign w_valid_g  = req_valid_i[r_grant_id];
  assign w_ready_g  = w_locked && (!r_tx_valid || tx_ready_i);
  assign w_accept   = w_ready_g && w_valid_g;
  assign w_acc_last = w_accept && req_last_i[r_grant_id];
  // Expiry only on an idle cycle, so a simultaneous last byte always wins.
  assign w_expire   = (IDLE_TIMEOUT != 0) && w_locked && !w_valid_g &&
                      (r_cnt == c_cnt_max);

  always_comb begin
    req_ready_o = '0;
    if (w_ready_g) begin
      req_ready_o[r_grant_id] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = LOCKED;
      LOCKED:  if (w_acc_last || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_id <= ID_W'(NUM_REQ - 1);
    end else if ((r_state == IDLE) && w_pick_any) begin
      r_grant_id <= w_pick_idx;
    end
  end

  // Output buffer is independent of the FSM so a held byte survives exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (w_accept) begin
      r_tx_data  <= w_bytes[r_grant_id];
      r_tx_valid <= 1'b1;
    end else if (tx_ready_i) begin
      r_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (!w_locked || w_accept || w_expire) begin
        r_cnt <= '0;
      end else if (!w_valid_g && (IDLE_TIMEOUT != 0)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign grant_id_o = r_grant_id;
  assign busy_o     = w_locked;
  assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Scoreboard bench for uart_tx_arbiter with directed message vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [7:0]           tx_data_o;
  logic                 tx_valid_o;
  logic                 tx_ready_i;
  logic [ID_W-1:0]      grant_id_o;
  logic                 busy_o;
  logic                 timeout_o;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [8:0] rq [NUM_REQ][$];
  logic [7:0] exp_q [$];
  int         glog [$];
  logic       prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last, input logic expect_out);
    rq[r].push_back({last, d});
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
          rq[3].size() == 0 && exp_q.size() == 0 && !busy_o && !tx_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // Requester model: presents the head of each queue, pops on handshake.
  initial begin
    logic [NUM_REQ-1:0] fire;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid_i & req_ready_o;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid_i[i]         = 1'b1;
          req_data_i[8*i +: 8]   = rq[i][0][7:0];
          req_last_i[i]          = rq[i][0][8];
        end else begin
          req_valid_i[i] = 1'b0;
          req_last_i[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: compares every transferred byte and logs each new grant.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_valid_o && tx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_extra: got %0h expected no byte", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, tx_data_o}, {24'd0, e});
        end
      end
      if (busy_o && !prev_busy) glog.push_back(int'(grant_id_o));
      prev_busy = busy_o;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_g [6];
    exp_g = '{0, 1, 3, 0, 1, 3};
    reset      = 1'b0;
    tx_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data_o},  32'd0);
    chk("rst_ready",    {28'd0, req_ready_o}, 32'd0);
    chk("rst_busy",     {31'd0, busy_o},     32'd0);
    chk("rst_timeout",  {31'd0, timeout_o},  32'd0);
    chk("rst_grant",    {30'd0, grant_id_o}, 32'd3);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single two-byte message from requester 2
    #2;
    push(2, 8'h48, 1'b0, 1'b1);
    push(2, 8'h69, 1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (req_valid_i[2]) break;
      n++;
    end
    chk("t1_valid_seen", {31'd0, req_valid_i[2]}, 32'd1);
    @(posedge clk); #2;
    chk("t1_grant", {30'd0, grant_id_o}, 32'd2);
    chk("t1_busy",  {31'd0, busy_o},     32'd1);
    @(posedge clk); #2;
    chk("t1_byte0", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, 8'h48});
    @(posedge clk); #2;
    chk("t1_byte1", {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, 8'h69});
    chk("t1_busy_drop", {31'd0, busy_o}, 32'd0);
    wait_drain("t1_drain");

    // Two contending 3-byte messages held from reset
    @(negedge clk); reset = 1'b0;
    for (int b = 0; b < 3; b++) push(0, 8'hA0 + 8'(b), (b == 2), 1'b1);
    for (int b = 0; b < 3; b++) push(1, 8'hB0 + 8'(b), (b == 2), 1'b1);
    repeat (2) @(negedge clk); reset = 1'b1;
    wait_drain("t2_drain");

    // Repeated 1-byte messages on 0, 1 and 3: fair rotation
    @(negedge clk); reset = 1'b0;
    push(0, 8'hC0, 1'b1, 1'b1); push(1, 8'hD0, 1'b1, 1'b1); push(3, 8'hE0, 1'b1, 1'b1);
    push(0, 8'hC1, 1'b1, 1'b1); push(1, 8'hD1, 1'b1, 1'b1); push(3, 8'hE1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    glog.delete();
    reset = 1'b1;
    wait_drain("t3_drain");
    chk("t3_grant_count", glog.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < glog.size()) chk("t3_grant_order", glog[k], exp_g[k]);
    end

    // Back-pressure for 5 cycles
    @(posedge clk); #2;
    tx_ready_i = 1'b0;
    push(2, 8'h10, 1'b0, 1'b1);
    push(2, 8'h11, 1'b0, 1'b1);
    push(2, 8'h12, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (tx_valid_o) break;
    end
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_data",  {23'd0, tx_valid_o, tx_data_o}, {23'd0, 1'b1, 8'h10});
      chk("t4_ready_low",  {28'd0, req_ready_o}, 32'd0);
      chk("t4_no_timeout", {31'd0, timeout_o},   32'd0);
      @(posedge clk); #2;
    end
    tx_ready_i = 1'b1;
    wait_drain("t4_drain");

    // Stalled requester 1 reclaimed by timeout; requester 2 waiting
    push(1, 8'h55, 1'b0, 1'b1);
    push(2, 8'h77, 1'b1, 1'b1);
    n = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_valid_i[1] && req_ready_o[1]) break;
    end
    @(posedge clk);
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #2;
      n++;
      if (timeout_o) break;
    end
    chk("t5_timeout_delay", n, TMO);
    chk("t5_grant_kept", {30'd0, grant_id_o}, 32'd1);
    chk("t5_busy_drop",  {31'd0, busy_o},     32'd0);
    @(posedge clk); #2;
    chk("t5_pulse_width", {31'd0, timeout_o},  32'd0);
    chk("t5_next_grant",  {30'd0, grant_id_o}, 32'd2);
    wait_drain("t5_drain");

    // Reset in mid-message with a buffered byte
    tx_ready_i = 1'b0;
    push(3, 8'hE5, 1'b0, 1'b0);
    push(3, 8'hE6, 1'b0, 1'b0);
    push(3, 8'hE7, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (tx_valid_o) break;
    end
    chk("t6_buffered", {31'd0, tx_valid_o}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, tx_valid_o}, 32'd0);
    chk("t6_rst_busy",  {31'd0, busy_o},     32'd0);
    rq[3].delete();
    glog.delete();
    push(0, 8'hF0, 1'b1, 1'b1);
    push(1, 8'hF1, 1'b1, 1'b1);
    tx_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_drain("t6_drain");
    chk("t6_grant_count", glog.size(), 32'd2);
    if (glog.size() > 0) chk("t6_first_grant", glog[0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
